// File: rtl/cpu_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package cpu_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: BITS_PER_CYCLE shift-add (multiply)
// or restoring-subtract (divide) steps over a 2*XLEN accumulator.
module muldiv_step #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                is_div_i,
  input  logic [2*XLEN-1:0]   acc_i,
  input  logic [XLEN-1:0]     opnd_i,
  output logic [2*XLEN-1:0]   acc_o
);

  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem_ext;
  logic [XLEN:0]     diff;
  logic [XLEN:0]     sum;

  // Divide: acc = {remainder, dividend/quotient}; multiply: acc = {partial, multiplier}
  always_comb begin
    acc     = acc_i;
    rem_ext = '0;
    diff    = '0;
    sum     = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div_i) begin
        rem_ext = acc[2*XLEN-1:XLEN-1];
        diff    = rem_ext - {1'b0, opnd_i};
        if (!diff[XLEN]) begin
          acc = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
          acc = {rem_ext[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
      end else begin
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_i} : '0);
        acc = {sum, acc[XLEN-1:1]};
      end
    end
    acc_o = acc;
  end

endmodule

// File: rtl/exe_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operands are latched as magnitudes; signs are re-applied on the completion edge.
module exe_muldiv
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            cancel,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] hilo_wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned ITERS = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CW    = $clog2(ITERS + 1);

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*XLEN-1:0]    acc_q;
  logic [XLEN-1:0]      opnd_q;
  logic                 is_div_q;
  logic                 sign_q_q;
  logic                 sign_r_q;
  logic                 dz_q;
  logic [XLEN-1:0]      hi_q;
  logic [XLEN-1:0]      lo_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 neg1_c;
  logic                 neg2_c;
  logic [XLEN-1:0]      abs1_c;
  logic [XLEN-1:0]      abs2_c;
  logic                 accept_c;
  logic [2*XLEN-1:0]    step_acc_c;
  logic [2*XLEN-1:0]    prod_c;
  logic [XLEN-1:0]      quo_raw_c;
  logic [XLEN-1:0]      rem_raw_c;
  logic [XLEN-1:0]      quo_c;
  logic [XLEN-1:0]      rem_c;

  // Operand magnitudes; op[0]=0 marks the signed flavours
  always_comb begin
    neg1_c   = ~op[0] & src1[XLEN-1];
    neg2_c   = ~op[0] & src2[XLEN-1];
    abs1_c   = neg1_c ? -src1 : src1;
    abs2_c   = neg2_c ? -src2 : src2;
    accept_c = start & ~cancel & (state_q != ST_CALC);
  end

  muldiv_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc_c)
  );

  // Sign fix-up of the final iteration; divide-by-zero forces an all-ones quotient
  always_comb begin
    quo_raw_c = step_acc_c[XLEN-1:0];
    rem_raw_c = step_acc_c[2*XLEN-1:XLEN];
    prod_c    = sign_q_q ? -step_acc_c : step_acc_c;
    quo_c     = sign_q_q ? -quo_raw_c : quo_raw_c;
    rem_c     = sign_r_q ? -rem_raw_c : rem_raw_c;
    if (dz_q) begin
      quo_c = '1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (hi_we) hi_q <= hilo_wdata;
      if (lo_we) lo_q <= hilo_wdata;
      case (state_q)
        ST_CALC: begin
          acc_q <= step_acc_c;
          cnt_q <= cnt_q - CW'(1);
          if (cancel) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CW'(1)) begin
            // Completion overrides any MTHI/MTLO on the same edge
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (is_div_q) begin
              hi_q <= rem_c;
              lo_q <= quo_c;
            end else begin
              {hi_q, lo_q} <= prod_c;
            end
          end
        end
        default: begin
          if (accept_c) begin
            state_q  <= ST_CALC;
            busy_q   <= 1'b1;
            cnt_q    <= CW'(ITERS);
            is_div_q <= op[1];
            sign_q_q <= neg1_c ^ neg2_c;
            sign_r_q <= neg1_c;
            dz_q     <= op[1] & (src2 == '0);
            opnd_q   <= op[1] ? abs2_c : abs1_c;
            acc_q    <= {{XLEN{1'b0}}, (op[1] ? abs1_c : abs2_c)};
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed self-checking bench for exe_muldiv (1 and 4 bits per cycle builds).
module tb_exe_muldiv;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, start4, cancel;
  logic [1:0]  op;
  logic [31:0] src1, src2, hilo_wdata;
  logic        hi_we, lo_we;
  logic        busy, done, busy4, done4;
  logic [31:0] hi, lo, hi4, lo4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exe_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .cancel(cancel), .op(op),
    .src1(src1), .src2(src2), .hi_we(hi_we), .lo_we(lo_we),
    .hilo_wdata(hilo_wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  exe_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .start(start4), .cancel(cancel), .op(op),
    .src1(src1), .src2(src2), .hi_we(hi_we), .lo_we(lo_we),
    .hilo_wdata(hilo_wdata), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Launch on a negedge; returns cycles until done (0 on timeout)
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit use4, output int lat);
    op = o; src1 = a; src2 = b;
    if (use4) start4 = 1'b1; else start = 1'b1;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        start4 = 1'b0;
        chk($sformatf("busy_after_start%0d", int'(use4)), use4 ? busy4 : busy, 1'b1);
      end
      if ((use4 ? done4 : done) === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    bit seen;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{OP_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
    vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{OP_DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2};
    vecs[9] = '{OP_MULTU, 32'd2,         32'd3,         32'd0,         32'd6};

    resetn = 1'b0; start = 1'b0; start4 = 1'b0; cancel = 1'b0; op = 2'd0;
    src1 = '0; src2 = '0; hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    // Table-driven operations on the 1-bit-per-cycle build
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd33);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // MTLO in IDLE, then preset HI/LO for the cancel tests
    lo_we = 1'b1; hilo_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_idle", lo, 32'hDEAD_BEEF);
    hi_we = 1'b1; hilo_wdata = 32'h11;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; hilo_wdata = 32'h22;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mthi_preset", hi, 32'h11);
    chk("mtlo_preset", lo, 32'h22);

    // Cancel mid-CALC
    op = OP_MULTU; src1 = 32'd3; src2 = 32'd5; start = 1'b1;
    seen = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (done) seen = 1'b1;
      if (n == 11) begin
        cancel = 1'b0;
        chk("cancel_busy_low", busy, 0);
      end
      if (n == 10) cancel = 1'b1;
    end
    chk("cancel_no_done", 64'(seen), 0);
    chk("cancel_hi_kept", hi, 32'h11);
    chk("cancel_lo_kept", lo, 32'h22);

    // Start and cancel in the same cycle
    start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("startcancel_busy", busy, 0);
    seen = 1'b0;
    for (int n = 0; n < 36; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("startcancel_no_done", 64'(seen), 0);
    chk("startcancel_lo", lo, 32'h22);

    // MTHI on the completion edge loses to the result
    op = OP_MULTU; src1 = 32'd2; src2 = 32'd3; start = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 33) hi_we = 1'b0;
      if (done && lat == 0) lat = n;
      if (n == 32) begin
        hi_we = 1'b1;
        hilo_wdata = 32'hFFFF_FFFF;
      end
    end
    chk("collide_latency", 64'(lat), 33);
    chk("collide_hi", hi, 0);
    chk("collide_lo", lo, 6);

    // Asynchronous reset mid-CALC
    hi_we = 1'b1; hilo_wdata = 32'h55;
    @(negedge clk);
    hi_we = 1'b0;
    op = OP_MULTU; src1 = 32'd3; src2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 4-bits-per-cycle build, with a back-to-back start during DONE
    launch(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, lat);
    chk("b4_latency", 64'(lat), 9);
    chk("b4_product", {hi4, lo4}, 64'h0B00_EA4E_242D_2080);
    op = OP_MULTU; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF; start4 = 1'b1;
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start4 = 1'b0;
        chk("b2b_done_drop", done4, 0);
        chk("b2b_busy", busy4, 1);
      end
      if (done4) begin
        lat = n;
        break;
      end
    end
    chk("b2b_latency", 64'(lat), 9);
    chk("b2b_product", {hi4, lo4}, 64'hFFFF_FFFE_0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
